// File: rtl/carrier_search_ctrl.sv
// Carrier search sequencer: sweeps the NCO frequency word, measures I/Q envelope energy per step, locks to the best step.
// Optional CARRIER_THRESH_EN adds a minimum-energy threshold input that gates the final lock.
module carrier_search_ctrl #(
   parameter int unsigned IQ_WIDTH       = 13,
   parameter int unsigned PH_WIDTH       = 32,
   parameter int unsigned FW_START       = 238609294,
   parameter int unsigned FW_STEP        = 29826162,
   parameter int unsigned NUM_STEPS      = 16,
   parameter int unsigned SETTLE_SAMPLES = 8,
   parameter int unsigned MEAS_SAMPLES   = 64
) (
   input  logic                                      clk_36MHz,
   input  logic                                      rst,
   input  logic                                      start,
   input  logic                                      ce_in,
   input  logic signed [IQ_WIDTH-1:0]                env_I,
   input  logic signed [IQ_WIDTH-1:0]                env_Q,
`ifdef CARRIER_THRESH_EN
   input  logic [IQ_WIDTH+$clog2(MEAS_SAMPLES):0]    thresh,
`endif
   output logic [PH_WIDTH-1:0]                       freq_word,
   output logic                                      freq_update,
   output logic                                      busy,
   output logic                                      done,
   output logic                                      locked,
   output logic [7:0]                                best_index,
   output logic [IQ_WIDTH+$clog2(MEAS_SAMPLES):0]    best_energy
);

   localparam int unsigned ACC_W = IQ_WIDTH + 1 + $clog2(MEAS_SAMPLES);
   localparam int unsigned CNT_W = $clog2(MEAS_SAMPLES + SETTLE_SAMPLES + 1);
   localparam logic [CNT_W-1:0] MEAS_LAST   = CNT_W'(MEAS_SAMPLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_SAMPLES == 0) ? 0 : SETTLE_SAMPLES - 1);
   localparam logic [7:0]       IDX_LAST    = 8'(NUM_STEPS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SET,
      S_SETTLE,
      S_MEASURE,
      S_COMPARE,
      S_LOCK
   } state_t;

   state_t                state_q, state_d;
   logic [7:0]            idx_q, idx_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic [PH_WIDTH-1:0]   freq_word_q, freq_word_d;
   logic                  freq_update_q, freq_update_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  locked_q, locked_d;
   logic [7:0]            best_index_q, best_index_d;
   logic [ACC_W-1:0]      best_energy_q, best_energy_d;
   logic [ACC_W-1:0]      mag_sum;

   // Frequency word for a sweep index, wrapping modulo 2^PH_WIDTH.
   function automatic logic [PH_WIDTH-1:0] fw_of(input logic [7:0] idx);
      return PH_WIDTH'(FW_START) + PH_WIDTH'(PH_WIDTH'(idx) * PH_WIDTH'(FW_STEP));
   endfunction

   // Saturating magnitude: the most negative code maps to the largest positive one.
   function automatic logic [IQ_WIDTH-1:0] sat_abs(input logic signed [IQ_WIDTH-1:0] x);
      if (!x[IQ_WIDTH-1])
         return IQ_WIDTH'(x);
      else if (x[IQ_WIDTH-2:0] == '0)
         return {1'b0, {(IQ_WIDTH-1){1'b1}}};
      else
         return IQ_WIDTH'(-x);
   endfunction

   assign mag_sum = ACC_W'(sat_abs(env_I)) + ACC_W'(sat_abs(env_Q));

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      acc_d         = acc_q;
      freq_word_d   = freq_word_q;
      freq_update_d = 1'b0;
      busy_d        = busy_q;
      done_d        = 1'b0;
      locked_d      = locked_q;
      best_index_d  = best_index_q;
      best_energy_d = best_energy_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d       = S_SET;
               idx_d         = 8'd0;
               cnt_d         = '0;
               acc_d         = '0;
               best_index_d  = 8'd0;
               best_energy_d = '0;
               locked_d      = 1'b0;
               busy_d        = 1'b1;
               freq_word_d   = fw_of(8'd0);
               freq_update_d = 1'b1;
            end
         end
         S_SET: begin
            state_d = (SETTLE_SAMPLES == 0) ? S_MEASURE : S_SETTLE;
         end
         S_SETTLE: begin
            if (ce_in) begin
               if (cnt_q == SETTLE_LAST) begin
                  state_d = S_MEASURE;
                  cnt_d   = '0;
                  acc_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_MEASURE: begin
            if (ce_in) begin
               acc_d = acc_q + mag_sum;
               if (cnt_q == MEAS_LAST) begin
                  state_d = S_COMPARE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_COMPARE: begin
            // Strict compare keeps the lower index on ties.
            if ((acc_q > best_energy_q) || (idx_q == 8'd0)) begin
               best_energy_d = acc_q;
               best_index_d  = idx_q;
            end
            if (idx_q == IDX_LAST) begin
               state_d       = S_LOCK;
               busy_d        = 1'b0;
               done_d        = 1'b1;
               locked_d      = 1'b1;
               freq_word_d   = fw_of(best_index_d);
               freq_update_d = 1'b1;
`ifdef CARRIER_THRESH_EN
               if (best_energy_d < thresh) begin
                  locked_d    = 1'b0;
                  freq_word_d = PH_WIDTH'(FW_START);
               end
`endif
            end else begin
               state_d       = S_SET;
               idx_d         = idx_q + 8'd1;
               cnt_d         = '0;
               acc_d         = '0;
               freq_word_d   = fw_of(idx_q + 8'd1);
               freq_update_d = 1'b1;
            end
         end
         S_LOCK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_36MHz or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         idx_q         <= 8'd0;
         cnt_q         <= '0;
         acc_q         <= '0;
         freq_word_q   <= PH_WIDTH'(FW_START);
         freq_update_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         locked_q      <= 1'b0;
         best_index_q  <= 8'd0;
         best_energy_q <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         acc_q         <= acc_d;
         freq_word_q   <= freq_word_d;
         freq_update_q <= freq_update_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         locked_q      <= locked_d;
         best_index_q  <= best_index_d;
         best_energy_q <= best_energy_d;
      end
   end

   assign freq_word   = freq_word_q;
   assign freq_update = freq_update_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign locked      = locked_q;
   assign best_index  = best_index_q;
   assign best_energy = best_energy_q;

endmodule

// File: doc/carrier_search_ctrl.md
Name: carrier_search_ctrl

Overview:
- Sequencer that configures the NCO frequency word of the I/Q down-conversion datapath. It steps the word across a programmed range and measures complex-envelope energy at the CIC output rate at each step.
- When the sweep finishes, it locks the word to the step with the highest energy.
- Sits between the system control logic and the I/Q generator. Drives the generator's phase-increment input and consumes the decimated I/Q samples plus their clock-enable strobe.

Parameters:
- IQ_WIDTH, 13, signed width of env_I/env_Q.
- PH_WIDTH, 32, frequency-word width.
- FW_START, 238609294, first frequency word (2 MHz at 36 MHz fs).
- FW_STEP, 29826162, word increment per step (0.25 MHz).
- NUM_STEPS, 16, number of sweep points; range 2..256.
- SETTLE_SAMPLES, 8, decimated samples discarded after each retune (CIC settling); 0 allowed.
- MEAS_SAMPLES, 64, decimated samples accumulated per step; power of two, at least 1.

Ports:
- clk_36MHz  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request to begin a sweep.
- ce_in  in  1  decimated-sample strobe, one cycle per sample (1.8 MHz rate).
- env_I  in  IQ_WIDTH  signed I sample, valid when ce_in=1.
- env_Q  in  IQ_WIDTH  signed Q sample, valid when ce_in=1.
- freq_word  out  PH_WIDTH  NCO phase increment.
- freq_update  out  1  one-cycle pulse when freq_word changes.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse at sweep end.
- locked  out  1  high after a successful sweep until the next start or reset.
- best_index  out  8  winning step index.
- best_energy  out  IQ_WIDTH+1+log2(MEAS_SAMPLES)  winning accumulated energy.

Behaviour:
- Clock and reset: one clock, clk_36MHz. Reset rst is asynchronous, active-high.
- Reset values: freq_word=FW_START; freq_update, busy, done, locked=0; best_index=0; best_energy=0; FSM in IDLE.
- FSM states: IDLE, SET, SETTLE, MEASURE, COMPARE, LOCK.
- IDLE: start=1 moves to SET. In the same edge: step index=0, best_energy=0, best_index=0, locked=0, busy=1.
- SET (1 cycle):
  - freq_word = FW_START + idx*FW_STEP, computed modulo 2^PH_WIDTH (wrap allowed).
  - freq_update=1 for this cycle.
  - Sample counter cleared. Next state is SETTLE, or MEASURE if SETTLE_SAMPLES=0.
- SETTLE: count ce_in strobes. On the SETTLE_SAMPLES-th strobe go to MEASURE with accumulator=0.
- MEASURE:
  - On each ce_in: acc += |env_I| + |env_Q|.
  - |x| saturates, so the most negative value (-4096 at 13 bits) maps to 4095.
  - Accumulator width is IQ_WIDTH+1+log2(MEAS_SAMPLES); it never overflows.
  - After MEAS_SAMPLES strobes go to COMPARE.
- COMPARE (1 cycle):
  - If acc > best_energy (strictly greater), or idx=0, then best_energy=acc and best_index=idx. Ties keep the lower index.
  - If idx=NUM_STEPS-1 go to LOCK; otherwise idx++ and go to SET.
- LOCK (1 cycle):
  - freq_word = FW_START + best_index*FW_STEP; freq_update=1; done=1; busy=0; locked=1.
  - Next state IDLE.
- ce_in outside SETTLE/MEASURE is ignored.
- start while busy=1 is ignored. start in the LOCK cycle is also ignored.
- Timing: sweep length is NUM_STEPS*(SETTLE_SAMPLES+MEAS_SAMPLES) strobes plus 2*NUM_STEPS+1 cycles of overhead.
- Reset mid-sweep: immediate return to reset values. No done pulse.
- best_index/best_energy are live during the sweep; they are final only when done=1.

Optional Feature:
- Macro: CARRIER_THRESH_EN.
- When defined:
  - Extra input port thresh, width equal to best_energy.
  - In LOCK, if best_energy < thresh then: locked stays 0, freq_word returns to FW_START with freq_update=1, and done still pulses.
- When undefined: no thresh port, and every completed sweep asserts locked.

Test Plan:
- Sweep with default parameters and ce_in every 20 cycles. env_I=100, env_Q=-50 during step 5 only; 0 elsewhere. Required: done pulses; best_index=5; best_energy=9600; freq_word=387740104; locked=1.
- Constant env_I=10, env_Q=10 for every step. Required: ties resolve to best_index=0, best_energy=1280, freq_word=238609294.
- env_I=-4096, env_Q=-4096 at step 2. Required: best_energy=524160 (4095*2*64) with no overflow; best_index=2.
- Pulse start again at step 3 while busy. Required: ignored; the sweep completes normally with exactly one done pulse.
- Assert rst while in MEASURE of step 7. Required: all outputs return to reset values asynchronously; a following start runs a full sweep from idx 0.
- With CARRIER_THRESH_EN and thresh=20000, apply the stimulus of scenario 1. Required: done=1, locked=0, freq_word=238609294.
